// File: rtl/vit_ctrl_pkg.sv
// Shared state type and default sizing for the Viterbi block sequencer.
package vit_ctrl_pkg;

  localparam int unsigned VIT_MEM       = 2;
  localparam int unsigned VIT_BLOCK_LEN = 20;
  localparam int unsigned VIT_TIMEOUT   = 256;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    TAIL,
    WAIT,
    HOLD
  } vit_ctrl_state_e;

endpackage

// File: rtl/vit_ctrl_popcnt.sv
// Parameterised population count used for the sent/decoded bit-error tally.
module vit_ctrl_popcnt #(
  parameter int unsigned W = 20
) (
  input  logic [W-1:0]              vec_i,
  output logic [$clog2(W+1)-1:0]    cnt_o
);

  localparam int unsigned CW = $clog2(W + 1);

  always_comb begin
    cnt_o = '0;
    for (int unsigned i = 0; i < W; i++) begin
      cnt_o = cnt_o + CW'(vec_i[i]);
    end
  end

endmodule

// File: rtl/vit_blk_ctrl.sv
// Block sequencer: serialises a message block plus MEM tail zeros into the encoder,
// strobes traceback, then collects the decoded stream. VIT_CTRL_ERRCNT_EN adds bit_err_cnt.
module vit_blk_ctrl
  import vit_ctrl_pkg::*;
#(
  parameter int unsigned BLOCK_LEN = VIT_BLOCK_LEN,
  parameter int unsigned MEM       = VIT_MEM,
  parameter int unsigned TIMEOUT   = VIT_TIMEOUT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [BLOCK_LEN-1:0] msg_data,
  input  logic                 msg_valid,
  output logic                 msg_ready,
  output logic                 ux,
  output logic                 tb_en,
  input  logic                 dx,
  input  logic                 dx_oe,
  input  logic                 dec_error,
  output logic [BLOCK_LEN-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_err
`ifdef VIT_CTRL_ERRCNT_EN
  ,
  output logic [$clog2(BLOCK_LEN+1)-1:0] bit_err_cnt
`endif
);

  localparam int unsigned CW = $clog2(BLOCK_LEN + MEM + 1);
  localparam int unsigned RW = $clog2(BLOCK_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] BITS_LAST = CW'(BLOCK_LEN);
  localparam logic [CW-1:0] TAIL_LAST = CW'(BLOCK_LEN + MEM);
  localparam logic [RW-1:0] RX_FULL   = RW'(BLOCK_LEN);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT);

  vit_ctrl_state_e state_q, state_d;

  logic [BLOCK_LEN-1:0] shift_q, shift_d;
  logic [BLOCK_LEN-1:0] coll_q, coll_d;
  logic [BLOCK_LEN-1:0] data_q, data_d;
  logic [CW-1:0]        bcnt_q, bcnt_d;
  logic [RW-1:0]        rcnt_q, rcnt_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic ux_q, ux_d, tb_q, tb_d, rdy_q, rdy_d, vld_q, vld_d, err_q, err_d;
  logic collect, rx_full, timed_out, accept;

  assign accept    = (state_q == IDLE) && msg_valid && rdy_q;
  assign collect   = (state_q == SEND) || (state_q == TAIL) || (state_q == WAIT);
  assign rx_full   = (rcnt_d == RX_FULL);
  assign timed_out = (tcnt_q == TO_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // bcnt counts bits already driven on ux, including the one currently out.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)                    state_d = SEND;
      SEND:    if (bcnt_q == BITS_LAST)       state_d = TAIL;
      TAIL:    if (bcnt_q == TAIL_LAST)       state_d = WAIT;
      WAIT:    if (rx_full || timed_out)      state_d = HOLD;
      HOLD:    if (out_ready)                 state_d = IDLE;
      default:                                state_d = IDLE;
    endcase
  end

  always_comb begin
    rcnt_d = rcnt_q;
    coll_d = coll_q;
    if (accept) begin
      rcnt_d = '0;
      coll_d = '0;
    end else if (collect && dx_oe && (rcnt_q != RX_FULL)) begin
      coll_d = {coll_q[BLOCK_LEN-2:0], dx};
      rcnt_d = rcnt_q + 1'b1;
    end
  end

  always_comb begin
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    tcnt_d  = tcnt_q;
    data_d  = data_q;
    err_d   = err_q;
    ux_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = msg_data << 1;
          ux_d    = msg_data[BLOCK_LEN-1];
          bcnt_d  = CW'(1);
          err_d   = 1'b0;
        end
      end
      SEND, TAIL: begin
        if (bcnt_q != TAIL_LAST) bcnt_d = bcnt_q + 1'b1;
        if (state_d == SEND) begin
          ux_d    = shift_q[BLOCK_LEN-1];
          shift_d = shift_q << 1;
        end
        tcnt_d = '0;
      end
      WAIT: begin
        if (tcnt_q != TO_MAX) tcnt_d = tcnt_q + 1'b1;
        if (state_d == HOLD) begin
          if (rx_full) begin
            data_d = coll_d;
          end else begin
            err_d  = 1'b1;
            data_d = coll_d << (RX_FULL - rcnt_d);
          end
        end
      end
      default: ;
    endcase
    if (collect && dec_error) err_d = 1'b1;
    tb_d  = (state_d == TAIL) && (bcnt_d == TAIL_LAST);
    rdy_d = (state_d == IDLE);
    vld_d = (state_d == HOLD);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      coll_q  <= '0;
      data_q  <= '0;
      bcnt_q  <= '0;
      rcnt_q  <= '0;
      tcnt_q  <= '0;
      ux_q    <= 1'b0;
      tb_q    <= 1'b0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      coll_q  <= coll_d;
      data_q  <= data_d;
      bcnt_q  <= bcnt_d;
      rcnt_q  <= rcnt_d;
      tcnt_q  <= tcnt_d;
      ux_q    <= ux_d;
      tb_q    <= tb_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign msg_ready = rdy_q;
  assign ux        = ux_q;
  assign tb_en     = tb_q;
  assign out_data  = data_q;
  assign out_valid = vld_q;
  assign out_err   = err_q;

`ifdef VIT_CTRL_ERRCNT_EN
  logic [BLOCK_LEN-1:0] sent_q;
  logic [RW-1:0]        pop, errcnt_q;

  vit_ctrl_popcnt #(.W(BLOCK_LEN)) u_popcnt (
    .vec_i (data_d ^ sent_q),
    .cnt_o (pop)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sent_q   <= '0;
      errcnt_q <= '0;
    end else begin
      if (accept) sent_q <= msg_data;
      if ((state_q == WAIT) && (state_d == HOLD)) errcnt_q <= pop;
    end
  end

  assign bit_err_cnt = errcnt_q;
`endif

endmodule
